// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb controller: state encoding, screen
// limits, default timing/geometry, and the clamped blast-origin helper.
package bomb_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, EXPLODE, COOLDOWN} bomb_state_e;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  localparam int DEF_FUSE_FRAMES  = 120;
  localparam int DEF_BLAST_FRAMES = 30;
  localparam int DEF_COOL_FRAMES  = 30;
  localparam int DEF_GRID         = 16;
  localparam int DEF_BLAST_S      = 48;

  // Centre the blast square on the grid cell, clamped into [0, lim].
  function automatic logic [9:0] blast_origin(input logic [9:0] place,
                                              input int off, input int lim);
    int p;
    p = int'(place);
    if (p < off)            return '0;
    else if (p - off > lim) return 10'(lim);
    else                    return 10'(p - off);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; holds at zero until reloaded.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bomb_ctrl.sv
// Bomb lifecycle controller: edge-triggered drop, fuse, blast, cooldown,
// with chain detonation and a screen-clamped blast square.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = DEF_FUSE_FRAMES,
  parameter int BLAST_FRAMES = DEF_BLAST_FRAMES,
  parameter int COOL_FRAMES  = DEF_COOL_FRAMES,
  parameter int GRID         = DEF_GRID,
  parameter int BLAST_S      = DEF_BLAST_S
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       bomb_drop,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  input  logic       chain_in,
  output logic       bomb_ack,
  output logic [9:0] bombX,
  output logic [9:0] bombY,
  output logic [9:0] bombS,
  output logic       armed,
  output logic       exploding
);

  localparam int         OFF   = (BLAST_S - GRID) / 2;
  localparam int         X_LIM = SCREEN_X_MAX - BLAST_S;
  localparam int         Y_LIM = SCREEN_Y_MAX - BLAST_S;
  localparam logic [9:0] SNAP  = ~10'(GRID - 1);

  bomb_state_e state, nxt;
  logic        drop_q;
  logic [9:0]  place_x, place_y;
  logic        accept, load, zero;
  logic [7:0]  load_val;

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = '0;
    accept   = (state == IDLE) && bomb_drop && !drop_q;
    case (state)
      IDLE: if (accept) begin
        nxt = ARMED; load = 1'b1; load_val = 8'(FUSE_FRAMES - 1);
      end
      ARMED: if (chain_in || zero) begin
        nxt = EXPLODE; load = 1'b1; load_val = 8'(BLAST_FRAMES - 1);
      end
      EXPLODE: if (zero) begin
        nxt = COOLDOWN; load = 1'b1; load_val = 8'(COOL_FRAMES - 1);
      end
      COOLDOWN: if (zero) begin
        nxt = IDLE; load = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  // drop_q resets high so a drop already held at reset must be re-pressed.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      drop_q  <= 1'b1;
      place_x <= '0;
      place_y <= '0;
    end else begin
      state  <= nxt;
      drop_q <= bomb_drop;
      if (accept) begin
        place_x <= userX & SNAP;
        place_y <= userY & SNAP;
      end
    end
  end

  frame_timer #(.W(8)) u_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (load),
    .load_val  (load_val),
    .en        (state != IDLE),
    .zero      (zero)
  );

  assign bomb_ack  = accept;
  assign armed     = (state == ARMED);
  assign exploding = (state == EXPLODE);
  assign bombS     = exploding ? 10'(BLAST_S) : '0;
  assign bombX     = armed ? place_x :
                     exploding ? blast_origin(place_x, OFF, X_LIM) : '0;
  assign bombY     = armed ? place_y :
                     exploding ? blast_origin(place_y, OFF, Y_LIM) : '0;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Directed table-driven bench for bomb_ctrl at default parameters.
module tb_bomb_ctrl;

  logic       Reset, frame_clk;
  logic       bomb_drop, chain_in;
  logic [9:0] userX, userY;
  logic       bomb_ack, armed, exploding;
  logic [9:0] bombX, bombY, bombS;

  int checks = 0;
  int failures = 0;

  bomb_ctrl dut (
    .Reset(Reset), .frame_clk(frame_clk), .bomb_drop(bomb_drop),
    .userX(userX), .userY(userY), .chain_in(chain_in),
    .bomb_ack(bomb_ack), .bombX(bombX), .bombY(bombY), .bombS(bombS),
    .armed(armed), .exploding(exploding)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string      name;
    logic       drop;
    logic [9:0] ux, uy;
    logic       chain;
    int         cyc;
    logic       ack, arm, expl;
    logic [9:0] bx, by, bs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic chk_outs(input string n, input logic arm, input logic expl,
                          input logic [9:0] bx, input logic [9:0] by, input logic [9:0] bs);
    chk({n, ".armed"}, 32'(armed), 32'(arm));
    chk({n, ".exploding"}, 32'(exploding), 32'(expl));
    chk({n, ".bombX"}, 32'(bombX), 32'(bx));
    chk({n, ".bombY"}, 32'(bombY), 32'(by));
    chk({n, ".bombS"}, 32'(bombS), 32'(bs));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  initial begin
    // name, drop, ux, uy, chain, cyc, ack, armed, exploding, bx, by, bs
    tbl.push_back('{"idle",          0,  0,  0,  0,   2, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"accept",        1, 37, 50,  0,   1, 1, 1, 0,  32,  48,  0});
    tbl.push_back('{"armed",         1, 37, 50,  0, 119, 0, 1, 0,  32,  48,  0});
    tbl.push_back('{"expl",          1, 37, 50,  0,   1, 0, 0, 1,  16,  32, 48});
    tbl.push_back('{"expl_end",      1, 37, 50,  0,  29, 0, 0, 1,  16,  32, 48});
    tbl.push_back('{"cool",          1, 37, 50,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"cool_end",      1, 37, 50,  0,  29, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"sticky_idle",   1, 37, 50,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"sticky_hold",   1, 37, 50,  0,   3, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"release",       0,  5,470,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"clamp_acc",     1,  5,470,  0,   1, 1, 1, 0,   0, 464,  0});
    tbl.push_back('{"clamp_arm",     0,  5,470,  0, 119, 0, 1, 0,   0, 464,  0});
    tbl.push_back('{"clamp_expl",    0,  5,470,  0,   1, 0, 0, 1,   0, 431, 48});
    tbl.push_back('{"clamp_expl_end",0,  5,470,  0,  29, 0, 0, 1,   0, 431, 48});
    tbl.push_back('{"cool2",         0,  5,470,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"cool_drop",     1,  5,470,  0,  10, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"cool_low",      0,  5,470,  0,  19, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"cool_last",     1,  5,470,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"drop_low",      0,630,  8,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"hi_acc",        1,630,  8,  0,   1, 1, 1, 0, 624,   0,  0});
    tbl.push_back('{"arm9",          0,630,  8,  0,   9, 0, 1, 0, 624,   0,  0});
    tbl.push_back('{"chain",         0,630,  8,  1,   1, 0, 0, 1, 591,   0, 48});
    tbl.push_back('{"chain_expl",    0,630,  8,  0,  29, 0, 0, 1, 591,   0, 48});
    tbl.push_back('{"chain_cool",    0,630,  8,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"chain_cool_end",0,630,  8,  0,  29, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"back_idle",     0,630,  8,  0,   1, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"chain_idle",    0,630,  8,  1,   3, 0, 0, 0,   0,   0,  0});
    tbl.push_back('{"idle_acc",      1,630,  8,  0,   1, 1, 1, 0, 624,   0,  0});

    Reset = 1'b1; bomb_drop = 1'b0; chain_in = 1'b0; userX = '0; userY = '0;
    #2;
    chk("reset.ack", 32'(bomb_ack), 32'd0);
    chk_outs("reset", 0, 0, 0, 0, 0);
    step(2);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      bomb_drop = tbl[i].drop;
      userX     = tbl[i].ux;
      userY     = tbl[i].uy;
      chain_in  = tbl[i].chain;
      #1;
      chk({tbl[i].name, ".ack"}, 32'(bomb_ack), 32'(tbl[i].ack));
      step(tbl[i].cyc);
      chk_outs(tbl[i].name, tbl[i].arm, tbl[i].expl, tbl[i].bx, tbl[i].by, tbl[i].bs);
    end

    // Reset mid-blast, with bomb_drop held high across reset.
    chain_in = 1'b0; userX = 10'd37; userY = 10'd50;
    step(120);
    chk_outs("pre_rst", 0, 1, 591, 0, 48);
    #2 Reset = 1'b1;
    #1;
    chk_outs("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst.ack", 32'(bomb_ack), 32'd0);
    step(2);
    Reset = 1'b0;
    step(3);
    chk("post_rst.ack", 32'(bomb_ack), 32'd0);
    chk_outs("post_rst", 0, 0, 0, 0, 0);
    bomb_drop = 1'b0;
    step(1);
    bomb_drop = 1'b1;
    #1;
    chk("rearm.ack", 32'(bomb_ack), 32'd1);
    step(1);
    chk("rearm.ack_drop", 32'(bomb_ack), 32'd0);
    chk_outs("rearm", 1, 0, 32, 48, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
